// File: rtl/atsc_seg_source.sv
// ATSC data-segment symbol source with an AXI4-Stream master output.
// Each segment is four sync symbols followed by SEG_LEN-4 LFSR-driven 8-level
// data symbols. Every symbol is scaled by a gain, offset by a DC term and
// saturated onto I. Q carries a constant DC value.
module atsc_seg_source #(
   parameter int          SEG_LEN   = 832,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic        [15:0] cfg_num_segs,
   input  logic        [7:0]  cfg_amp,
   input  logic signed [15:0] cfg_dc_i,
   input  logic signed [15:0] cfg_dc_q,
   input  logic        [11:0] cfg_spp,
   output logic        [31:0] out_TDATA,
   output logic               out_TVALID,
   input  logic               out_TREADY,
   output logic               out_TLAST,
   output logic               busy,
   output logic        [15:0] seg_count
);

   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_SYNC = 2'd1;
   localparam logic [1:0]  ST_DATA = 2'd2;
   localparam logic [15:0] SEG_LEN16 = 16'(SEG_LEN);
   localparam logic [15:0] SEG_LAST  = 16'(SEG_LEN - 1);

   // Clamp the 18-bit signed sum onto the 16-bit signed sample range.
   function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
      if (v > 18'sd32767)
         return 16'sh7FFF;
      else if (v < -18'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

   // Configuration captured on an accepted start.
   logic        [15:0] num_segs_r;
   logic        [7:0]  amp_r;
   logic signed [15:0] dc_i_r;
   logic signed [15:0] dc_q_r;
   logic        [15:0] spp_eff_r;

   // p0: generator state describing the next beat to be loaded.
   logic [1:0]  state_p0;
   logic [15:0] idx_p0;
   logic [15:0] lfsr_p0;
   logic [15:0] pkt_p0;
   logic [15:0] segs_p0;

   // p1: beat held in the output register.
   logic last_p1;
   logic seg_end_p1;
   logic fin_p1;
   logic stop_pend;

   logic               accept_start;
   logic               stop_any;
   logic               hs;
   logic               final_now;
   logic               load;
   logic               seg_last_p0;
   logic               count_done_p0;
   logic               beat_fin_p0;
   logic               pkt_last_p0;
   logic        [15:0] lfsr_next_p0;
   logic signed [3:0]  level_p0;
   logic signed [12:0] prod_p0;
   logic signed [17:0] sum_p0;

   assign accept_start = start & ~busy;
   assign stop_any     = busy & (stop | stop_pend);
   assign hs           = out_TVALID & out_TREADY;
   // A segment-end beat already sitting in the output register becomes the
   // final beat if a stop is seen before (or while) it is accepted.
   assign final_now    = out_TVALID & (fin_p1 | (seg_end_p1 & stop_any));
   assign load         = (state_p0 != ST_IDLE) & (~out_TVALID | out_TREADY) & ~final_now;
   assign out_TLAST    = out_TVALID & (last_p1 | (seg_end_p1 & stop_any));

   assign seg_last_p0   = (idx_p0 == SEG_LAST);
   assign count_done_p0 = (num_segs_r != 16'd0) && (segs_p0 == num_segs_r - 16'd1);
   assign beat_fin_p0   = seg_last_p0 & (count_done_p0 | stop_any);
   assign pkt_last_p0   = (pkt_p0 == spp_eff_r - 16'd1);
   assign lfsr_next_p0  = {lfsr_p0[0] ^ lfsr_p0[2] ^ lfsr_p0[3] ^ lfsr_p0[5], lfsr_p0[15:1]};

   // Symbol level: fixed sync pattern, or 2*v-7 from the low LFSR bits.
   always_comb begin
      level_p0 = 4'sd0;
      if (state_p0 == ST_SYNC)
         level_p0 = (idx_p0[1:0] == 2'd0 || idx_p0[1:0] == 2'd3) ? 4'sd5 : -4'sd5;
      else
         level_p0 = {~lfsr_p0[2], lfsr_p0[1:0], 1'b1};
   end

   assign prod_p0 = level_p0 * $signed({1'b0, amp_r});
   assign sum_p0  = {{5{prod_p0[12]}}, prod_p0} + {{2{dc_i_r[15]}}, dc_i_r};

   // Latch configuration only when a start is accepted.
   always_ff @(posedge ap_clk) begin
      if (accept_start) begin
         num_segs_r <= cfg_num_segs;
         amp_r      <= cfg_amp;
         dc_i_r     <= cfg_dc_i;
         dc_q_r     <= cfg_dc_q;
         spp_eff_r  <= (cfg_spp == 12'd0) ? SEG_LEN16 : {4'd0, cfg_spp};
      end
   end

   // Generator FSM, symbol index, LFSR and packet/segment counters.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n || accept_start) begin
         state_p0 <= accept_start && ap_rst_n ? ST_SYNC : ST_IDLE;
         idx_p0   <= 16'd0;
         lfsr_p0  <= LFSR_SEED;
         pkt_p0   <= 16'd0;
         segs_p0  <= 16'd0;
      end else if (load) begin
         if (state_p0 == ST_DATA)
            lfsr_p0 <= lfsr_next_p0;
         pkt_p0 <= pkt_last_p0 ? 16'd0 : pkt_p0 + 16'd1;
         if (seg_last_p0) begin
            idx_p0   <= 16'd0;
            segs_p0  <= segs_p0 + 16'd1;
            state_p0 <= beat_fin_p0 ? ST_IDLE : ST_SYNC;
         end else begin
            idx_p0 <= idx_p0 + 16'd1;
            if (idx_p0 == 16'd3)
               state_p0 <= ST_DATA;
         end
      end else if (hs && final_now) begin
         state_p0 <= ST_IDLE;
      end
   end

   // ---- p0 -> p1: output register, refilled when empty or being drained ----
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         out_TVALID <= 1'b0;
         out_TDATA  <= 32'd0;
         last_p1    <= 1'b0;
         seg_end_p1 <= 1'b0;
         fin_p1     <= 1'b0;
      end else if (load) begin
         out_TVALID <= 1'b1;
         out_TDATA  <= {sat16(sum_p0), dc_q_r};
         last_p1    <= pkt_last_p0 | beat_fin_p0;
         seg_end_p1 <= seg_last_p0;
         fin_p1     <= beat_fin_p0;
      end else if (hs) begin
         out_TVALID <= 1'b0;
         last_p1    <= 1'b0;
         seg_end_p1 <= 1'b0;
         fin_p1     <= 1'b0;
      end
   end

   // Busy flag, pending stop and count of fully transferred segments.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         busy      <= 1'b0;
         stop_pend <= 1'b0;
         seg_count <= 16'd0;
      end else if (accept_start) begin
         busy      <= 1'b1;
         stop_pend <= 1'b0;
         seg_count <= 16'd0;
      end else begin
         if (hs && seg_end_p1)
            seg_count <= seg_count + 16'd1;
         if (hs && final_now) begin
            busy      <= 1'b0;
            stop_pend <= 1'b0;
         end else if (busy && stop) begin
            stop_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_atsc_seg_source.sv
// Directed bench for atsc_seg_source: reset values, sync/data symbols, gain
// and saturation, packetisation, stop handling, backpressure and mid-run reset.
module tb_atsc_seg_source;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        start;
   logic        stop;
   logic [15:0] cfg_num_segs;
   logic [7:0]  cfg_amp;
   logic [15:0] cfg_dc_i;
   logic [15:0] cfg_dc_q;
   logic [11:0] cfg_spp;
   logic [31:0] out_TDATA;
   logic        out_TVALID;
   logic        out_TREADY;
   logic        out_TLAST;
   logic        busy;
   logic [15:0] seg_count;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] got_data[$];
   logic        got_last[$];
   logic [31:0] exp_data[$];
   logic        exp_last[$];
   logic        timeout;
   logic        tv_n1;
   logic        tv_n2;
   int          stall_bad;

   atsc_seg_source #(.SEG_LEN(832), .LFSR_SEED(16'hACE1)) dut (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .start        (start),
      .stop         (stop),
      .cfg_num_segs (cfg_num_segs),
      .cfg_amp      (cfg_amp),
      .cfg_dc_i     (cfg_dc_i),
      .cfg_dc_q     (cfg_dc_q),
      .cfg_spp      (cfg_spp),
      .out_TDATA    (out_TDATA),
      .out_TVALID   (out_TVALID),
      .out_TREADY   (out_TREADY),
      .out_TLAST    (out_TLAST),
      .busy         (busy),
      .seg_count    (seg_count)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic set_cfg(input logic [15:0] ns, input logic [7:0] amp,
                          input logic [15:0] dci, input logic [15:0] dcq,
                          input logic [11:0] spp);
      cfg_num_segs = ns;
      cfg_amp      = amp;
      cfg_dc_i     = dci;
      cfg_dc_q     = dcq;
      cfg_spp      = spp;
   endtask

   // Reference beat stream: sync pattern, LFSR data levels, gain, DC, clamp.
   task automatic build_expected(input int total, input int amp, input int dci,
                                 input logic [15:0] dcq, input int spp);
      logic [15:0] lfsr;
      int          idx, level, ival, spp_eff;
      logic [31:0] word;
      exp_data.delete();
      exp_last.delete();
      lfsr    = 16'hACE1;
      spp_eff = (spp == 0) ? 832 : spp;
      for (int k = 0; k < total; k++) begin
         idx = k % 832;
         if (idx < 4) begin
            level = (idx == 0 || idx == 3) ? 5 : -5;
         end else begin
            level = 2 * int'(lfsr[2:0]) - 7;
            lfsr  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
         end
         ival = level * amp + dci;
         if (ival > 32767) ival = 32767;
         else if (ival < -32768) ival = -32768;
         word = {ival[15:0], dcq};
         exp_data.push_back(word);
         exp_last.push_back(((k + 1) % spp_eff == 0) || (k == total - 1));
      end
   endtask

   // Pulse start, then record accepted beats until busy falls (or abort/timeout).
   // Config inputs are scrambled right after start to expose late latching.
   task automatic run_stream(input int rdy_mode, input int stop_at, input int abort_at,
                             input int restart_at, input int max_cycles);
      int          cyc;
      logic        stop_sent, prev_v, prev_r, prev_l;
      logic [31:0] prev_d;
      got_data.delete();
      got_last.delete();
      timeout   = 1'b0;
      stall_bad = 0;
      stop_sent = 1'b0;
      prev_v    = 1'b0;
      prev_r    = 1'b0;
      prev_l    = 1'b0;
      prev_d    = 32'd0;
      cyc       = 0;
      @(negedge ap_clk);
      start      = 1'b1;
      out_TREADY = 1'b1;
      @(negedge ap_clk);
      start = 1'b0;
      set_cfg(16'd3, 8'hA5, 16'h1111, 16'h2222, 12'd7);
      #1 tv_n1 = out_TVALID;
      while (1) begin
         @(negedge ap_clk);
         out_TREADY = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
         stop  = 1'b0;
         if (stop_at > 0 && !stop_sent && got_data.size() == stop_at - 1) begin
            stop      = 1'b1;
            stop_sent = 1'b1;
         end
         start = (restart_at > 0 && cyc == restart_at);
         #1;
         if (cyc == 0) tv_n2 = out_TVALID;
         if (prev_v && !prev_r && (out_TVALID !== 1'b1 || out_TDATA !== prev_d || out_TLAST !== prev_l))
            stall_bad++;
         prev_v = out_TVALID;
         prev_r = out_TREADY;
         prev_d = out_TDATA;
         prev_l = out_TLAST;
         if (out_TVALID === 1'b1 && out_TREADY) begin
            got_data.push_back(out_TDATA);
            got_last.push_back(out_TLAST);
         end
         cyc++;
         if (abort_at > 0 && got_data.size() == abort_at) break;
         if (got_data.size() > 0 && busy === 1'b0) break;
         if (cyc >= max_cycles) begin
            timeout = 1'b1;
            break;
         end
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_reset;
      ap_rst_n   = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      out_TREADY = 1'b0;
      set_cfg(16'd1, 8'd1, 16'd0, 16'd0, 12'd0);
      repeat (3) @(posedge ap_clk);
      #1;
      n_checks++; if (out_TVALID !== 1'b0) $display("FAIL reset_tvalid got %b want 0", out_TVALID); else n_pass++;
      n_checks++; if (out_TLAST !== 1'b0) $display("FAIL reset_tlast got %b want 0", out_TLAST); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (out_TDATA !== 32'd0) $display("FAIL reset_tdata got %h want 0", out_TDATA); else n_pass++;
      n_checks++; if (seg_count !== 16'd0) $display("FAIL reset_segcount got %0d want 0", seg_count); else n_pass++;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [31:0] sync_exp [4];
      int bad, first;
      sync_exp = '{32'h00050000, 32'hFFFB0000, 32'hFFFB0000, 32'h00050000};
      set_cfg(16'd1, 8'd1, 16'd0, 16'd0, 12'd0);
      run_stream(0, 0, 0, 0, 3000);
      build_expected(832, 1, 0, 16'h0000, 0);
      n_checks++; if (timeout !== 1'b0) $display("FAIL basic_timeout got %b want 0", timeout); else n_pass++;
      n_checks++; if (tv_n1 !== 1'b0) $display("FAIL basic_tvalid_early got %b want 0", tv_n1); else n_pass++;
      n_checks++; if (tv_n2 !== 1'b1) $display("FAIL basic_tvalid_latency got %b want 1", tv_n2); else n_pass++;
      n_checks++; if (got_data.size() != 832) $display("FAIL basic_beats got %0d want 832", got_data.size()); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (got_data[k] !== sync_exp[k]) $display("FAIL basic_sync%0d got %h want %h", k, got_data[k], sync_exp[k]);
         else n_pass++;
      end
      bad = 0; first = -1;
      for (int k = 0; k < got_data.size() && k < exp_data.size(); k++)
         if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k]) begin
            if (first < 0) first = k;
            bad++;
         end
      n_checks++; if (bad != 0) $display("FAIL basic_stream beat %0d got %h/%b want %h/%b (%0d bad)", first, got_data[first], got_last[first], exp_data[first], exp_last[first], bad); else n_pass++;
      n_checks++; if (seg_count !== 16'd1) $display("FAIL basic_segcount got %0d want 1", seg_count); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_backpressure;
      int bad, first;
      set_cfg(16'd1, 8'd1, 16'd0, 16'd0, 12'd0);
      run_stream(1, 0, 0, 0, 6000);
      build_expected(832, 1, 0, 16'h0000, 0);
      n_checks++; if (timeout !== 1'b0) $display("FAIL bp_timeout got %b want 0", timeout); else n_pass++;
      n_checks++; if (got_data.size() != 832) $display("FAIL bp_beats got %0d want 832", got_data.size()); else n_pass++;
      bad = 0; first = -1;
      for (int k = 0; k < got_data.size() && k < exp_data.size(); k++)
         if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k]) begin
            if (first < 0) first = k;
            bad++;
         end
      n_checks++; if (bad != 0) $display("FAIL bp_stream beat %0d got %h want %h (%0d bad)", first, got_data[first], exp_data[first], bad); else n_pass++;
      n_checks++; if (stall_bad != 0) $display("FAIL bp_stall_stable got %0d changes want 0", stall_bad); else n_pass++;
   endtask

   task automatic test_spp;
      int bad, first, nlast;
      set_cfg(16'd1, 8'd1, 16'd0, 16'd0, 12'd100);
      run_stream(0, 0, 0, 0, 3000);
      build_expected(832, 1, 0, 16'h0000, 100);
      n_checks++; if (got_data.size() != 832) $display("FAIL spp_beats got %0d want 832", got_data.size()); else n_pass++;
      bad = 0; first = -1; nlast = 0;
      for (int k = 0; k < got_data.size() && k < exp_data.size(); k++) begin
         if (got_last[k] === 1'b1) nlast++;
         if (got_last[k] !== exp_last[k]) begin
            if (first < 0) first = k;
            bad++;
         end
      end
      n_checks++; if (bad != 0) $display("FAIL spp_tlast beat %0d got %b want %b", first + 1, got_last[first], exp_last[first]); else n_pass++;
      n_checks++; if (nlast != 9) $display("FAIL spp_tlast_count got %0d want 9", nlast); else n_pass++;
   endtask

   task automatic test_amp_sat;
      int bad, first;
      set_cfg(16'd1, 8'd255, 16'h7F00, 16'h1234, 12'd0);
      run_stream(0, 0, 0, 0, 3000);
      build_expected(832, 255, 32512, 16'h1234, 0);
      n_checks++; if (got_data[0] !== 32'h7FFF1234) $display("FAIL amp_sync0 got %h want 7fff1234", got_data[0]); else n_pass++;
      n_checks++; if (got_data[1] !== {16'(31237), 16'h1234}) $display("FAIL amp_sync1 got %h want 7a051234", got_data[1]); else n_pass++;
      bad = 0; first = -1;
      for (int k = 0; k < got_data.size() && k < exp_data.size(); k++)
         if (got_data[k] !== exp_data[k]) begin
            if (first < 0) first = k;
            bad++;
         end
      n_checks++; if (bad != 0 || got_data.size() != 832) $display("FAIL amp_stream beat %0d got %h want %h (%0d bad, %0d beats)", first, got_data[first], exp_data[first], bad, got_data.size()); else n_pass++;
   endtask

   task automatic test_stop;
      int bad, first;
      set_cfg(16'd0, 8'd1, 16'd0, 16'd0, 12'd0);
      run_stream(0, 1000, 0, 0, 4000);
      build_expected(1664, 1, 0, 16'h0000, 0);
      n_checks++; if (got_data.size() != 1664) $display("FAIL stop_beats got %0d want 1664", got_data.size()); else n_pass++;
      bad = 0; first = -1;
      for (int k = 0; k < got_data.size() && k < exp_data.size(); k++)
         if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k]) begin
            if (first < 0) first = k;
            bad++;
         end
      n_checks++; if (bad != 0) $display("FAIL stop_stream beat %0d got %h/%b want %h/%b", first, got_data[first], got_last[first], exp_data[first], exp_last[first]); else n_pass++;
      n_checks++; if (seg_count !== 16'd2) $display("FAIL stop_segcount got %0d want 2", seg_count); else n_pass++;
   endtask

   task automatic test_stop_boundary;
      set_cfg(16'd0, 8'd1, 16'd0, 16'd0, 12'd0);
      run_stream(0, 832, 0, 0, 3000);
      n_checks++; if (got_data.size() != 832) $display("FAIL stopb_beats got %0d want 832", got_data.size()); else n_pass++;
      n_checks++; if (got_last[831] !== 1'b1) $display("FAIL stopb_tlast got %b want 1", got_last[831]); else n_pass++;
      n_checks++; if (seg_count !== 16'd1) $display("FAIL stopb_segcount got %0d want 1", seg_count); else n_pass++;
   endtask

   task automatic test_idle_stop_and_busy_start;
      int bad, first;
      @(negedge ap_clk); stop = 1'b1;
      @(negedge ap_clk); stop = 1'b0;
      set_cfg(16'd2, 8'd1, 16'd0, 16'd0, 12'd0);
      run_stream(0, 0, 0, 500, 4000);
      build_expected(1664, 1, 0, 16'h0000, 0);
      n_checks++; if (got_data.size() != 1664) $display("FAIL idle_beats got %0d want 1664", got_data.size()); else n_pass++;
      bad = 0; first = -1;
      for (int k = 0; k < got_data.size() && k < exp_data.size(); k++)
         if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k]) begin
            if (first < 0) first = k;
            bad++;
         end
      n_checks++; if (bad != 0) $display("FAIL idle_stream beat %0d got %h want %h", first, got_data[first], exp_data[first]); else n_pass++;
      n_checks++; if (seg_count !== 16'd2) $display("FAIL idle_segcount got %0d want 2", seg_count); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int bad, first;
      set_cfg(16'd2, 8'd1, 16'd0, 16'd0, 12'd0);
      run_stream(0, 0, 1000, 0, 3000);
      n_checks++; if (seg_count !== 16'd1) $display("FAIL rstmid_segcount_before got %0d want 1", seg_count); else n_pass++;
      @(negedge ap_clk);
      ap_rst_n   = 1'b0;
      out_TREADY = 1'b0;
      @(posedge ap_clk);
      #1;
      n_checks++; if (out_TVALID !== 1'b0) $display("FAIL rstmid_tvalid got %b want 0", out_TVALID); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (seg_count !== 16'd0 || out_TDATA !== 32'd0) $display("FAIL rstmid_clear got %0d/%h want 0/0", seg_count, out_TDATA); else n_pass++;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      set_cfg(16'd1, 8'd1, 16'd0, 16'd0, 12'd0);
      run_stream(0, 0, 0, 0, 3000);
      build_expected(832, 1, 0, 16'h0000, 0);
      bad = 0; first = -1;
      for (int k = 0; k < got_data.size() && k < exp_data.size(); k++)
         if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k]) begin
            if (first < 0) first = k;
            bad++;
         end
      n_checks++; if (bad != 0 || got_data.size() != 832) $display("FAIL rstmid_restart beat %0d got %h want %h (%0d beats)", first, got_data[first], exp_data[first], got_data.size()); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_spp;
      test_amp_sat;
      test_stop;
      test_stop_boundary;
      test_idle_stop_and_busy_start;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
